dither_scan_controller: RTL and testbench
=========================================

# dither_scan_controller

Raster timing and configuration controller for the VGA serial display dithering path. Generates pixel counters, the `visible` window and the active-low syncs. Also drives the dithering datapath's enable and threshold, accepting new settings over a valid/ready handshake and applying them only at frame boundaries. Syncs are delayed to line up with the registered dither output.

## Interface
- `H_VISIBLE`, 640: active pixels per line
- `H_FRONT` / `H_SYNC` / `H_BACK`, 16 / 96 / 48: horizontal porch and sync widths, in pixels
- `V_VISIBLE`, 480: active lines per frame
- `V_FRONT` / `V_SYNC` / `V_BACK`, 10 / 2 / 33: vertical porch and sync widths, in lines
- `PIPE_LAT`, 1: dither datapath latency in pixel ticks; allowed range 0..4
- `THRESHOLD_DEFAULT`, 4: reset value of `threshold`
- `clk` in 1: single system clock
- `rst` in 1: asynchronous, active-low reset
- `pix_en` in 1: pixel tick; all raster state advances only when it is high
- `cfg_valid` in 1: a configuration word is offered
- `cfg_dither_en` in 1: requested dither enable (0 = bypass)
- `cfg_threshold` in 4: requested rounding threshold
- `cfg_ready` out 1: controller can accept a configuration word
- `hcount` out 10: current pixel column, 0..H_TOTAL-1
- `vcount` out 10: current line, 0..V_TOTAL-1
- `visible` out 1: high when `hcount < H_VISIBLE` and `vcount < V_VISIBLE`; feeds the dither `visible` input
- `frame_start` out 1: one-`clk` pulse when the raster wraps to (0,0)
- `dither_en` out 1: active dither enable
- `threshold` out 4: active threshold
- `hsync` out 1: active-low horizontal sync, delayed by PIPE_LAT
- `vsync` out 1: active-low vertical sync, delayed by PIPE_LAT

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Column counter, on a `pix_en` tick:
  - `hcount` increments.
  - At H_TOTAL-1 it wraps to 0 and `vcount` increments.
  - When `vcount` is at V_TOTAL-1 and `hcount` wraps, `vcount` wraps to 0.
- When `pix_en` is low, every register holds its value; `frame_start` is 0.
- `visible` and the raw syncs are registered from the next-state counters, so they are aligned with `hcount`/`vcount`.
- Raw hsync is low for `hcount` in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
- Raw vsync is low for `vcount` in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491.
- Raw syncs pass through a PIPE_LAT-stage shift register clocked on `pix_en` to produce `hsync`/`vsync`. With PIPE_LAT=0 the raw syncs are output directly.
- The configuration FSM has two states:
  - IDLE: `cfg_ready`=1. When `cfg_valid && cfg_ready`, the word is captured into a shadow register and the FSM goes to PENDING.
  - PENDING: `cfg_ready`=0 and `cfg_valid` is ignored. On the frame-wrap tick (`pix_en`, `hcount`=H_TOTAL-1, `vcount`=V_TOTAL-1), the shadow is copied to `dither_en`/`threshold`, `frame_start` pulses, and the FSM goes to IDLE.
- A word accepted in IDLE on the frame-wrap cycle itself is not applied at that wrap; it waits for the next one.
- `frame_start` pulses on every wrap, whether or not a configuration is pending.
- Active `dither_en`/`threshold` never change while `vcount < V_VISIBLE`, so there are no mid-frame changes.

## Timing
- Reset values:
  - `hcount`=0, `vcount`=0, `visible`=0, `frame_start`=0
  - `hsync`=1, `vsync`=1, sync pipeline stages all 1
  - `cfg_ready`=1, FSM=IDLE, `dither_en`=1, `threshold`=THRESHOLD_DEFAULT, shadow=defaults
- The first `pix_en` tick after reset release moves the raster to (1,0) with `visible`=1.
- All outputs are registered; nothing is combinational from inputs to outputs.
- Handshake latency: `cfg_ready` falls on the `clk` edge after acceptance, and rises on the same edge that applies the configuration.
- Config-to-effect latency runs from acceptance to the next frame wrap: up to one full frame, H_TOTAL*V_TOTAL ticks.
- `hsync`/`vsync` lag `visible` by exactly PIPE_LAT `pix_en` ticks.
- If `rst` asserts mid-frame or while PENDING, all state returns to reset values asynchronously and the pending word is discarded.

## Test plan
- Reset, then 3 `pix_en` ticks: outputs match reset values; then `hcount`=3, `vcount`=0, `visible`=1, `hsync`=`vsync`=1.
- Free-run one full frame with `pix_en` high: `hcount` wraps 799→0; `vcount` wraps 524→0; `frame_start` pulses once per 420000 ticks; `visible` is high on 307200 ticks.
- PIPE_LAT=1: `hsync` is low for exactly 96 ticks, starting 1 tick after `hcount` reaches 656; `vsync` is low for 2 lines starting 1 tick after line 490.
- Offer {0, 4'd9} at `vcount`=100: `cfg_ready` drops, `dither_en`/`threshold` stay {1,4}, and switch to {0,9} together with `frame_start`. A second word offered while pending is not accepted.
- Offer a word on the exact frame-wrap cycle while IDLE: it is accepted, not applied at this wrap, and applied at the following wrap.
- Gate `pix_en` to 1-in-4 cycles: counters advance once per 4 `clk`. Assert `rst` at `vcount`=200 while PENDING: everything returns to reset values and the pending word never takes effect.

Source files
------------

// File: rtl/dither_scan_controller.sv
// Raster timing and configuration controller for the VGA dithering path.
// Frame-synchronous config apply, PIPE_LAT-delayed active-low syncs.
module dither_scan_controller #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIPE_LAT  = 1,
  parameter logic [3:0] THRESHOLD_DEFAULT = 4'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       cfg_valid,
  input  logic       cfg_dither_en,
  input  logic [3:0] cfg_threshold,
  output logic       cfg_ready,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       visible,
  output logic       frame_start,
  output logic       dither_en,
  output logic [3:0] threshold,
  output logic       hsync,
  output logic       vsync
);

  localparam int H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_HI  =
    10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_HI  =
    10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [0:0] state;
  logic       sh_en;
  logic [3:0] sh_th;
  logic       hs_raw;
  logic       vs_raw;
  logic       h_last;
  logic       v_last;
  logic       wrap;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;

  assign h_last = (hcount == H_LAST);
  assign v_last = (vcount == V_LAST);
  assign wrap   = pix_en && h_last && v_last;

  // next-state raster position
  always_comb begin
    h_nxt = hcount + 10'd1;
    v_nxt = vcount;
    if (h_last) begin
      h_nxt = '0;
      v_nxt = v_last ? '0 : vcount + 10'd1;
    end
  end

  // raster counters, window and raw syncs, aligned to counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount      <= '0;
      vcount      <= '0;
      visible     <= 1'b0;
      hs_raw      <= 1'b1;
      vs_raw      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (pix_en) begin
        hcount  <= h_nxt;
        vcount  <= v_nxt;
        visible <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
        hs_raw  <= !((h_nxt >= HS_LO) && (h_nxt <= HS_HI));
        vs_raw  <= !((v_nxt >= VS_LO) && (v_nxt <= VS_HI));
      end
    end
  end

  // config handshake: capture in IDLE, apply at frame wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sh_en     <= 1'b1;
      sh_th     <= THRESHOLD_DEFAULT;
      dither_en <= 1'b1;
      threshold <= THRESHOLD_DEFAULT;
    end else if (state == PENDING) begin
      if (wrap) begin
        dither_en <= sh_en;
        threshold <= sh_th;
        state     <= IDLE;
      end
    end else if (cfg_valid) begin
      sh_en <= cfg_dither_en;
      sh_th <= cfg_threshold;
      state <= PENDING;
    end
  end

  assign cfg_ready = (state == IDLE);

  if (PIPE_LAT == 0) begin : g_nopipe
    assign hsync = hs_raw;
    assign vsync = vs_raw;
  end else begin : g_pipe
    logic [PIPE_LAT-1:0] hs_q;
    logic [PIPE_LAT-1:0] vs_q;

    // sync delay line matching the dither datapath latency
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hs_q <= '1;
        vs_q <= '1;
      end else if (pix_en) begin
        hs_q[0] <= hs_raw;
        vs_q[0] <= vs_raw;
        for (int i = 1; i < PIPE_LAT; i++) begin
          hs_q[i] <= hs_q[i-1];
          vs_q[i] <= vs_q[i-1];
        end
      end
    end

    assign hsync = hs_q[PIPE_LAT-1];
    assign vsync = vs_q[PIPE_LAT-1];
  end

endmodule

// File: tb/tb_dither_scan_controller.sv
// Bench for dither_scan_controller on a shrunken raster.
// Reference model feeds a scoreboard queue checked each tick.
module tb_dither_scan_controller;

  localparam int HV = 10, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;

  logic       clk;
  logic       rst;
  logic       pix_en;
  logic       cfg_valid;
  logic       cfg_dither_en;
  logic [3:0] cfg_threshold;
  logic       cfg_ready;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       visible;
  logic       frame_start;
  logic       dither_en;
  logic [3:0] threshold;
  logic       hsync;
  logic       vsync;

  dither_scan_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF),
    .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF),
    .V_SYNC(VS), .V_BACK(VB),
    .PIPE_LAT(1),
    .THRESHOLD_DEFAULT(4'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_en(pix_en),
    .cfg_valid(cfg_valid),
    .cfg_dither_en(cfg_dither_en),
    .cfg_threshold(cfg_threshold),
    .cfg_ready(cfg_ready),
    .hcount(hcount),
    .vcount(vcount),
    .visible(visible),
    .frame_start(frame_start),
    .dither_en(dither_en),
    .threshold(threshold),
    .hsync(hsync),
    .vsync(vsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int h; int v;
    bit vis; bit fs; bit hs; bit vs;
    bit rdy; bit en; int th;
  } exp_t;

  exp_t sbq[$];

  int nchk = 0;
  int nfail = 0;
  int nfs, nvis, nhs, nvs;

  int mh, mv, msth, mth;
  bit mvis, mfs, mrhs, mrvs, mhs, mvs;
  bit mpend, msen, men;

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; mvis = 0; mfs = 0;
    mrhs = 1; mrvs = 1; mhs = 1; mvs = 1;
    mpend = 0; msen = 1; msth = 4;
    men = 1; mth = 4;
  endtask

  task automatic push_exp();
    exp_t e;
    e.h = mh; e.v = mv; e.vis = mvis;
    e.fs = mfs; e.hs = mhs; e.vs = mvs;
    e.rdy = !mpend; e.en = men; e.th = mth;
    sbq.push_back(e);
  endtask

  task automatic check_out(string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, ".sbq_empty"}, 0, 1);
      return;
    end
    e = sbq.pop_front();
    chk({tag, ".hcount"}, 32'(hcount), e.h);
    chk({tag, ".vcount"}, 32'(vcount), e.v);
    chk({tag, ".visible"}, 32'(visible), 32'(e.vis));
    chk({tag, ".frame_start"},
        32'(frame_start), 32'(e.fs));
    chk({tag, ".hsync"}, 32'(hsync), 32'(e.hs));
    chk({tag, ".vsync"}, 32'(vsync), 32'(e.vs));
    chk({tag, ".cfg_ready"},
        32'(cfg_ready), 32'(e.rdy));
    chk({tag, ".dither_en"},
        32'(dither_en), 32'(e.en));
    chk({tag, ".threshold"}, 32'(threshold), e.th);
  endtask

  task automatic tick(string tag, bit pe, bit cv,
                      bit cen, logic [3:0] cth);
    bit wrap;
    pix_en = pe;
    cfg_valid = cv;
    cfg_dither_en = cen;
    cfg_threshold = cth;
    wrap = pe && (mh == HT-1) && (mv == VT-1);
    mfs = wrap;
    if (mpend) begin
      if (wrap) begin
        men = msen; mth = msth; mpend = 0;
      end
    end else if (cv) begin
      msen = cen; msth = int'(cth); mpend = 1;
    end
    if (pe) begin
      mhs = mrhs;
      mvs = mrvs;
      if (mh == HT-1) begin
        mh = 0;
        mv = (mv == VT-1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      mvis = (mh < HV) && (mv < VV);
      mrhs = !(mh >= HV+HF && mh < HV+HF+HS);
      mrvs = !(mv >= VV+VF && mv < VV+VF+VS);
    end
    push_exp();
    @(posedge clk);
    #1;
    check_out(tag);
    if (frame_start) nfs++;
    if (visible) nvis++;
    if (!hsync) nhs++;
    if (!vsync) nvs++;
  endtask

  task automatic run_until(int th, int tv);
    int n = 0;
    while (!(mh == th && mv == tv)) begin
      tick("run", 1'b1, 1'b0, 1'b0, 4'd0);
      n++;
      if (n > 2*FR) begin
        chk("run_until_timeout", 32'(n), 0);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    pix_en = 1'b0;
    cfg_valid = 1'b0;
    cfg_dither_en = 1'b0;
    cfg_threshold = 4'd0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    push_exp();
    check_out("reset");
    @(negedge clk);
    rst = 1'b1;

    repeat (3) tick("start", 1'b1, 1'b0, 1'b0, 4'd0);
    chk("start.h3", 32'(hcount), 3);
    chk("start.vis", 32'(visible), 1);

    nfs = 0; nvis = 0; nhs = 0; nvs = 0;
    repeat (FR) tick("frame", 1'b1, 1'b0, 1'b0, 4'd0);
    chk("frame.fs_count", 32'(nfs), 1);
    chk("frame.vis_count", 32'(nvis), HV*VV);
    chk("frame.hs_low", 32'(nhs), HS*VT);
    chk("frame.vs_low", 32'(nvs), VS*HT);

    run_until(HV+HF, 0);
    chk("hs.at_lo_raw_delay", 32'(hsync), 1);
    tick("hs1", 1'b1, 1'b0, 1'b0, 4'd0);
    chk("hs.low_after_1", 32'(hsync), 0);

    run_until(0, 2);
    tick("cfg0", 1'b1, 1'b1, 1'b0, 4'd9);
    chk("cfg0.ready", 32'(cfg_ready), 0);
    chk("cfg0.en_held", 32'(dither_en), 1);
    chk("cfg0.th_held", 32'(threshold), 4);
    repeat (3) tick("busy", 1'b1, 1'b1, 1'b1, 4'd3);
    run_until(HT-1, VT-1);
    tick("apply", 1'b1, 1'b0, 1'b0, 4'd0);
    chk("apply.fs", 32'(frame_start), 1);
    chk("apply.en", 32'(dither_en), 0);
    chk("apply.th", 32'(threshold), 9);
    chk("apply.ready", 32'(cfg_ready), 1);

    run_until(HT-1, VT-1);
    tick("wrapoffer", 1'b1, 1'b1, 1'b1, 4'd5);
    chk("wrapoffer.fs", 32'(frame_start), 1);
    chk("wrapoffer.en", 32'(dither_en), 0);
    chk("wrapoffer.th", 32'(threshold), 9);
    chk("wrapoffer.ready", 32'(cfg_ready), 0);
    run_until(HT-1, VT-1);
    tick("wrap2", 1'b1, 1'b0, 1'b0, 4'd0);
    chk("wrap2.en", 32'(dither_en), 1);
    chk("wrap2.th", 32'(threshold), 5);

    for (int i = 0; i < 40; i++)
      tick("gate", (i % 4) == 0, 1'b0, 1'b0, 4'd0);
    chk("gate.h10", 32'(hcount), 10);
    chk("gate.v0", 32'(vcount), 0);

    n = 0;
    while (mv != 4 && n < 8*FR) begin
      tick("gate", (n % 4) == 0, 1'b0, 1'b0, 4'd0);
      n++;
    end
    chk("gate.reach_v4", 32'(vcount), 4);
    tick("cfg1", 1'b0, 1'b1, 1'b0, 4'd2);
    chk("cfg1.ready", 32'(cfg_ready), 0);
    for (int i = 0; i < 6; i++)
      tick("gate", (i % 4) == 0, 1'b0, 1'b0, 4'd0);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    push_exp();
    check_out("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    repeat (FR + 5) tick("post", 1'b1, 1'b0, 1'b0, 4'd0);
    chk("post.en", 32'(dither_en), 1);
    chk("post.th", 32'(threshold), 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
